decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the 16-bit lab CPU, between fetch and execute. Splits each instruction into fields and control signals, holds them in an output pipeline register with valid/ready handshake, inserts one-cycle load-use bubbles, and supports flush on taken branch. Successor to the combinational decoder: adds width parameters, backpressure, hazard stalls and illegal-opcode reporting.

---
 rtl/decoder_pkg.sv | 50 +++++
 rtl/instr_ctrl_lut.sv | 117 +++++++++++
 rtl/decode_stage.sv | 131 +++++++++++++
 tb/tb_decode_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the lab CPU decode stage: default field widths,
// opcode and ALU operation encodings, and the registered control bundle.
package decoder_pkg;

  localparam int unsigned OP_W_DEF   = 4;
  localparam int unsigned REG_AW_DEF = 2;
  localparam int unsigned IMM_W_DEF  = 8;

  typedef enum logic [3:0] {
    OP_LW   = 4'h0,
    OP_SW   = 4'h1,
    OP_ADD  = 4'h2,
    OP_ADDI = 4'h3,
    OP_INV  = 4'h4,
    OP_AND  = 4'h5,
    OP_ANDI = 4'h6,
    OP_OR   = 4'h7,
    OP_ORI  = 4'h8,
    OP_SRA  = 4'h9,
    OP_SLL  = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_CLR  = 4'hD
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_AND    = 3'b001,
    ALU_OR     = 3'b010,
    ALU_INV    = 3'b011,
    ALU_SRA    = 3'b100,
    ALU_SLL    = 3'b101,
    ALU_SUB    = 3'b110,
    ALU_PASS_B = 3'b111
  } aluop_e;

  typedef struct packed {
    logic   reg_dst;
    logic   reg_write;
    logic   alu_src1;
    logic   alu_src2;
    logic   mem_write;
    logic   mem_to_reg;
    logic   branch;
    logic   branch_ne;
    aluop_e alu_op;
    logic   illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_ctrl_lut.sv
// Combinational opcode -> control bundle and source-register use flags.
// Opcodes outside the defined set produce an all-disabled bundle flagged illegal.
module instr_ctrl_lut
  import decoder_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl,
  output logic            use_rs,
  output logic            use_rt
);

  logic [31:0] op_ext;
  assign op_ext = 32'(opcode);

  // Decode table: defaults first, then per-opcode enables.
  always_comb begin
    ctrl   = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (op_ext)
      32'(OP_LW): begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src2   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        use_rs          = 1'b1;
      end
      32'(OP_SW): begin
        ctrl.alu_src2  = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      32'(OP_ADD): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      32'(OP_ADDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        use_rs         = 1'b1;
      end
      32'(OP_INV): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_INV;
        use_rs         = 1'b1;
      end
      32'(OP_AND): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_AND;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      32'(OP_ANDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.alu_op    = ALU_AND;
        use_rs         = 1'b1;
      end
      32'(OP_OR): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OR;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      32'(OP_ORI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.alu_op    = ALU_OR;
        use_rs         = 1'b1;
      end
      32'(OP_SRA): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.alu_op    = ALU_SRA;
        use_rs         = 1'b1;
      end
      32'(OP_SLL): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.alu_op    = ALU_SLL;
        use_rs         = 1'b1;
      end
      32'(OP_BEQ): begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      32'(OP_BNE): begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
      end
      32'(OP_CLR): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src1  = 1'b1;
        ctrl.alu_op    = ALU_PASS_B;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split, control decode, output
// pipeline register with valid/ready handshake, flush, load-use bubbles.
// Define DECODE_LOAD_USE_STALL_EN to enable load-use hazard detection;
// otherwise stall is tied low and hazards are left to forwarding/compiler.
module decode_stage
  import decoder_pkg::*;
#(
  parameter  int unsigned OP_W    = OP_W_DEF,
  parameter  int unsigned REG_AW  = REG_AW_DEF,
  parameter  int unsigned IMM_W   = IMM_W_DEF,
  localparam int unsigned INSTR_W = OP_W + 2 * REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [REG_AW-1:0]  rt_addr,
  output logic [REG_AW-1:0]  rd_addr,
  output logic [IMM_W-1:0]   immediate,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrc1,
  output logic               ALUSrc2,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               Branch,
  output logic               BranchNe,
  output logic [2:0]         ALUOp,
  output logic               stall,
  output logic               illegal
);

  logic [OP_W-1:0]   dec_opcode;
  logic [REG_AW-1:0] dec_rs;
  logic [REG_AW-1:0] dec_rt;
  logic [REG_AW-1:0] dec_rd;
  logic [IMM_W-1:0]  dec_imm;
  ctrl_t             dec_ctrl;
  logic              use_rs;
  logic              use_rt;
  ctrl_t             ctrl_q;
  logic              xfer;
  logic              leave;

  assign dec_opcode = instr[INSTR_W-1 -: OP_W];
  assign dec_rs     = instr[INSTR_W-OP_W-1 -: REG_AW];
  assign dec_rt     = instr[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
  assign dec_imm    = instr[IMM_W-1:0];
  assign dec_rd     = instr[IMM_W-1 -: REG_AW];

  instr_ctrl_lut #(
    .OP_W (OP_W)
  ) u_lut (
    .opcode (dec_opcode),
    .ctrl   (dec_ctrl),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  assign in_ready = (!out_valid || out_ready) && !stall && !flush;
  assign xfer     = in_valid && in_ready;
  assign leave    = out_valid && out_ready;

`ifdef DECODE_LOAD_USE_STALL_EN
  logic              ld_busy;
  logic [REG_AW-1:0] ld_dst;

  // Arm the hazard window for exactly one cycle after an LW hands off;
  // mem_to_reg is set only for LW, so it identifies the load.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ld_busy <= 1'b0;
      ld_dst  <= '0;
    end else begin
      ld_busy <= leave && ctrl_q.mem_to_reg;
      ld_dst  <= rt_addr;
    end
  end

  assign stall = in_valid && ld_busy &&
                 ((use_rs && (dec_rs == ld_dst)) || (use_rt && (dec_rt == ld_dst)));
`else
  logic lint_unused;
  assign lint_unused = ^{use_rs, use_rt};
  assign stall       = 1'b0;
`endif

  // Output pipeline register: load on transfer, drop valid when consumed,
  // hold while backpressured; flush wins over everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      rd_addr   <= '0;
      immediate <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      opcode    <= dec_opcode;
      rs_addr   <= dec_rs;
      rt_addr   <= dec_rt;
      rd_addr   <= dec_rd;
      immediate <= dec_imm;
      ctrl_q    <= dec_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign RegWrite = ctrl_q.reg_write;
  assign ALUSrc1  = ctrl_q.alu_src1;
  assign ALUSrc2  = ctrl_q.alu_src2;
  assign MemWrite = ctrl_q.mem_write;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign Branch   = ctrl_q.branch;
  assign BranchNe = ctrl_q.branch_ne;
  assign ALUOp    = ctrl_q.alu_op;
  assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (default widths). Expected behaviour
// comes from an opcode-set reference decoder and a cycle-level handshake model.
module tb_decode_stage;

`ifdef DECODE_LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [1:0]  rs_addr, rt_addr, rd_addr;
  logic [7:0]  immediate;
  logic        RegDst, RegWrite, ALUSrc1, ALUSrc2, MemWrite, MemToReg, Branch, BranchNe;
  logic [2:0]  ALUOp;
  logic        stall;
  logic        illegal;

  decode_stage #(
    .OP_W   (4),
    .REG_AW (2),
    .IMM_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .immediate (immediate),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .ALUSrc1   (ALUSrc1),
    .ALUSrc2   (ALUSrc2),
    .MemWrite  (MemWrite),
    .MemToReg  (MemToReg),
    .Branch    (Branch),
    .BranchNe  (BranchNe),
    .ALUOp     (ALUOp),
    .stall     (stall),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {op, rs, rt, rd, imm, RegDst, RegWrite, ALUSrc1, ALUSrc2, MemWrite,
  //  MemToReg, Branch, BranchNe, ALUOp, illegal}
  logic [29:0] dut_vec;
  assign dut_vec = {opcode, rs_addr, rt_addr, rd_addr, immediate,
                    RegDst, RegWrite, ALUSrc1, ALUSrc2, MemWrite, MemToReg,
                    Branch, BranchNe, ALUOp, illegal};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  bit          m_valid;
  logic [29:0] m_vec;
  bit          m_ld_busy;
  logic [1:0]  m_ld_dst;
  bit          last_xfer;

  function automatic logic [29:0] ref_decode(input logic [15:0] i);
    logic [3:0] op;
    logic [2:0] aop;
    logic       ill, rdst, rw, s1, s2, mw, m2r, br, bne;
    op   = i[15:12];
    ill  = (op >= 4'hE);
    rw   = op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD};
    rdst = op inside {4'h2, 4'h4, 4'h5, 4'h7, 4'hD};
    s2   = op inside {4'h0, 4'h1, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA};
    s1   = (op == 4'hD);
    mw   = (op == 4'h1);
    m2r  = (op == 4'h0);
    br   = op inside {4'hB, 4'hC};
    bne  = (op == 4'hC);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: aop = 3'b000;
      4'h5, 4'h6:             aop = 3'b001;
      4'h7, 4'h8:             aop = 3'b010;
      4'h4:                   aop = 3'b011;
      4'h9:                   aop = 3'b100;
      4'hA:                   aop = 3'b101;
      4'hB, 4'hC:             aop = 3'b110;
      4'hD:                   aop = 3'b111;
      default:                aop = 3'b000;
    endcase
    return {op, i[11:10], i[9:8], i[7:6], i[7:0],
            rdst, rw, s1, s2, mw, m2r, br, bne, aop, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [15:0] ins, input bit ordy);
    logic [3:0] op;
    bit         urs, urt, e_stall, e_rdy, xf;
    @(negedge clk);
    rst_n = r; flush = f; in_valid = iv; instr = ins; out_ready = ordy;
    #1;
    op      = ins[15:12];
    urs     = (op <= 4'hC);
    urt     = op inside {4'h1, 4'h2, 4'h5, 4'h7, 4'hB, 4'hC};
    e_stall = iv && m_ld_busy &&
              ((urs && ins[11:10] == m_ld_dst) || (urt && ins[9:8] == m_ld_dst));
    e_rdy   = (!m_valid || ordy) && !e_stall && !f;
    chk("stall", {31'b0, stall}, {31'b0, e_stall});
    chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) chk("bundle", {2'b0, dut_vec}, {2'b0, m_vec});
    @(posedge clk);
    xf        = iv && e_rdy;
    last_xfer = r && xf;
    if (!r) begin
      m_valid = 0; m_vec = '0; m_ld_busy = 0; m_ld_dst = '0;
    end else if (f) begin
      m_valid = 0; m_ld_busy = 0;
    end else begin
      m_ld_busy = STALL_EN && m_valid && ordy && (m_vec[29:26] == 4'h0);
      m_ld_dst  = m_vec[23:22];
      if (xf) begin
        m_valid = 1; m_vec = ref_decode(ins);
      end else if (ordy) begin
        m_valid = 0;
      end
    end
  endtask

  // Present an instruction until the model says it was taken (bounded).
  task automatic send(input logic [15:0] ins, input bit ordy);
    int unsigned k;
    k = 0;
    do begin
      cyc(1, 0, 1, ins, ordy);
      k++;
    end while (!last_xfer && k < 8);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 16'h0000, 1);
  endtask

  initial begin
    logic [15:0] ins;
    rst_n = 0; flush = 0; in_valid = 0; instr = '0; out_ready = 1;
    m_valid = 0; m_vec = '0; m_ld_busy = 0; m_ld_dst = '0; last_xfer = 0;

    // Reset state
    cyc(0, 0, 1, 16'h2800, 1);
    cyc(0, 0, 1, 16'h2800, 1);
    #1;
    chk("reset_vec", {1'b0, out_valid, dut_vec}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);

    // Every opcode with random register/immediate fields, streaming
    for (int i = 0; i < 16; i++) begin
      ins = {i[3:0], 12'($urandom)};
      send(ins, 1);
    end
    idle();

    // Directed decode points
    send(16'h7780, 1);
    #1;
    chk("or_ctrl", {27'b0, RegDst, RegWrite, ALUOp}, {27'b0, 5'b11010});
    chk("or_fields", {26'b0, rs_addr, rt_addr, rd_addr}, {26'b0, 6'b011110});
    send(16'hE000, 1);
    #1;
    chk("illegal_ctrl", {27'b0, illegal, RegWrite, MemWrite, Branch, out_valid},
        {27'b0, 5'b10001});
    idle();
    idle();

    // Load-use: LW rt=2, gap, ADD rs=2 lands in the hazard window
    send(16'h0200, 1);
    idle();
    cyc(1, 0, 1, 16'h2800, 1);
    #1;
    chk("lu_bubble", {31'b0, out_valid}, {31'b0, !STALL_EN});
    if (!last_xfer) send(16'h2800, 1);
    idle();
    // Back-to-back LW / dependent LW, then ADD on the same register
    send(16'h0200, 1);
    send(16'h0A00, 1);
    send(16'h2800, 1);
    idle();
    idle();

    // Backpressure: held bundle, nothing lost or duplicated
    send(16'h3123, 1);
    cyc(1, 0, 1, 16'h5456, 0);
    cyc(1, 0, 1, 16'h5456, 0);
    cyc(1, 0, 1, 16'h5456, 0);
    #1;
    chk("hold_vec", {2'b0, dut_vec}, {2'b0, ref_decode(16'h3123)});
    send(16'h5456, 1);
    idle();

    // Flush beats a simultaneous transfer
    send(16'h2123, 1);
    cyc(1, 1, 1, 16'h3ABC, 1);
    #1;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    idle();

    // Reset mid-stream, then resume
    send(16'h7780, 1);
    cyc(0, 0, 1, 16'h2800, 1);
    #1;
    chk("rst_mid", {1'b0, out_valid, dut_vec}, 32'h0);
    send(16'h2800, 1);
    idle();

    // Randomized traffic, LW-heavy to exercise the hazard window
    for (int n = 0; n < 600; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 9) < 3) ins[15:12] = 4'h0;
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
